rns_reverse_conv: RTL and testbench

RNS_REVERSE_CONV -- requirements
Module: rns_reverse_conv

---
 rtl/rns_pkg.sv | 15 +
 rtl/rns_mod129_fold.sv | 15 +
 rtl/rns_reverse_conv.sv | 109 ++++++++++
 tb/tb_rns_reverse_conv.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared constants and helpers for the {129, 256} residue number system.
package rns_pkg;
   localparam int MOD_A       = 129;
   localparam int MOD_B       = 256;
   localparam int INV_B_MOD_A = 64;
   localparam int RES_W       = 8;
   localparam int BIN_W       = 16;

   localparam logic [RES_W-1:0] MOD_A_R = RES_W'(MOD_A);

   // One conditional subtract is enough: any 8-bit value is below 2*129.
   function automatic logic [RES_W-1:0] red129(input logic [RES_W-1:0] x);
      return (x >= MOD_A_R) ? x - MOD_A_R : x;
   endfunction
endpackage

// File: rtl/rns_mod129_fold.sv
// 14-bit value reduced mod 129 by folding the upper 7 bits (2^7 == -1 mod 129).
module rns_mod129_fold
   import rns_pkg::*;
(
   input  logic [13:0]      a_i,
   output logic [RES_W-1:0] res_o
);

   logic [8:0] sum;

   // lo - hi + 129 lies in 2..256, so a single subtract lands in 0..128.
   assign sum   = {2'b00, a_i[6:0]} + 9'(MOD_A) - {2'b00, a_i[13:7]};
   assign res_o = (sum >= 9'(MOD_A)) ? RES_W'(sum - 9'(MOD_A)) : RES_W'(sum);

endmodule

// File: rtl/rns_reverse_conv.sv
// Three-stage {129, 256} residue to binary converter with valid/ready flow control.
module rns_reverse_conv
   import rns_pkg::*;
#(
   parameter int TAG_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RES_W-1:0] r129,
   input  logic [RES_W-1:0] r256,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BIN_W-1:0] dout,
   output logic [TAG_W-1:0] tag_out,
   output logic             range_err
);

   logic             s1_v_q, s2_v_q, s3_v_q;
   logic             s1_v_d, s2_v_d, s3_v_d;
   logic             en1, en2, en3;

   logic [RES_W-1:0] s1_r256_q, s1_d_q, s1_d_d;
   logic [TAG_W-1:0] s1_tag_q;
   logic             s1_err_q, s1_err_d;

   logic [RES_W-1:0] s2_r256_q, s2_t_q, s2_t_d;
   logic [TAG_W-1:0] s2_tag_q;
   logic             s2_err_q;

   logic [BIN_W-1:0] dout_q;
   logic [TAG_W-1:0] tag_q;
   logic             err_q;

   logic [RES_W-1:0] r129m, r256m;
   logic [8:0]       dif;

   // A stage may load when empty or when its occupant moves on this cycle.
   assign en3      = !s3_v_q | out_ready;
   assign en2      = !s2_v_q | en3;
   assign en1      = !s1_v_q | en2;
   assign in_ready = en1;

   assign s1_v_d = en1 ? in_valid : s1_v_q;
   assign s2_v_d = en2 ? s1_v_q   : s2_v_q;
   assign s3_v_d = en3 ? s2_v_q   : s3_v_q;

   always_comb begin
      r129m    = red129(r129);
      r256m    = red129(r256);
      dif      = {1'b0, r129m} - {1'b0, r256m};
      s1_d_d   = dif[8] ? RES_W'(dif + 9'(MOD_A)) : RES_W'(dif);
      s1_err_d = (r129 >= MOD_A_R);
   end

   // Multiplying by the inverse 64 is a 6-bit shift ahead of the fold.
   rns_mod129_fold u_fold (
      .a_i   ({s1_d_q, 6'b000000}),
      .res_o (s2_t_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         s3_v_q    <= 1'b0;
         s1_r256_q <= '0;
         s1_d_q    <= '0;
         s1_tag_q  <= '0;
         s1_err_q  <= 1'b0;
         s2_r256_q <= '0;
         s2_t_q    <= '0;
         s2_tag_q  <= '0;
         s2_err_q  <= 1'b0;
         dout_q    <= '0;
         tag_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         s3_v_q <= s3_v_d;
         if (en1 && in_valid) begin
            s1_r256_q <= r256;
            s1_d_q    <= s1_d_d;
            s1_tag_q  <= tag_in;
            s1_err_q  <= s1_err_d;
         end
         if (en2 && s1_v_q) begin
            s2_r256_q <= s1_r256_q;
            s2_t_q    <= s2_t_d;
            s2_tag_q  <= s1_tag_q;
            s2_err_q  <= s1_err_q;
         end
         if (en3 && s2_v_q) begin
            dout_q <= {s2_t_q, s2_r256_q};
            tag_q  <= s2_tag_q;
            err_q  <= s2_err_q;
         end
      end
   end

   assign out_valid = s3_v_q;
   assign dout      = dout_q;
   assign tag_out   = tag_q;
   assign range_err = err_q;

endmodule

// File: tb/tb_rns_reverse_conv.sv
// Bench for rns_reverse_conv: known vectors, backpressure, reset, random and full sweep.
module tb_rns_reverse_conv;

   typedef struct {
      logic [7:0]  r129;
      logic [7:0]  r256;
      logic [2:0]  tag;
      logic [15:0] dout;
      logic        err;
   } vec_t;

   typedef struct {
      logic [15:0] dout;
      logic [2:0]  tag;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  r129;
   logic [7:0]  r256;
   logic [2:0]  tag_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dout;
   logic [2:0]  tag_out;
   logic        range_err;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb[$];
   exp_t cur_e;
   logic acc;
   logic hold_v;
   logic [15:0] hold_dout;

   rns_reverse_conv #(.TAG_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .r129      (r129),
      .r256      (r256),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .tag_out   (tag_out),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Chinese remainder by search: the unique X below 33024 with both residues.
   function automatic exp_t model(input int a, input int b, input int tag);
      exp_t e;
      e.dout = '0;
      e.tag  = 3'(tag);
      e.err  = (a >= 129);
      for (int x = b; x < 33024; x += 256)
         if (x % 129 == a % 129) e.dout = 16'(x);
      return e;
   endfunction

   // One clock: observe handshakes at the falling edge, then step past the rising edge.
   task automatic cyc();
      exp_t x;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sb.push_back(cur_e);
      if (hold_v) begin
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_dout", int'(dout), int'(hold_dout));
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("stale_out", int'(out_valid), 0);
         else begin
            x = sb.pop_front();
            chk("sb_dout", int'(dout), int'(x.dout));
            chk("sb_tag", int'(tag_out), int'(x.tag));
            chk("sb_err", int'(range_err), int'(x.err));
         end
      end
      hold_v    = out_valid && !out_ready;
      hold_dout = dout;
      @(posedge clk);
      #1;
   endtask

   task automatic set_item(input int a, input int b, input int t);
      in_valid = 1'b1;
      r129     = 8'(a);
      r256     = 8'(b);
      tag_in   = 3'(t);
      cur_e    = model(a, b, t);
   endtask

   vec_t vecs[9];
   int   idx;
   int   budget;
   int   bp_a[4];
   int   bp_b[4];

   initial begin
      vecs[0] = '{8'd97,  8'd232, 3'd1, 16'd1000,  1'b0};
      vecs[1] = '{8'd128, 8'd255, 3'd2, 16'd33023, 1'b0};
      vecs[2] = '{8'd0,   8'd0,   3'd3, 16'd0,     1'b0};
      vecs[3] = '{8'd130, 8'd1,   3'd4, 16'd1,     1'b1};
      vecs[4] = '{8'd1,   8'd1,   3'd5, 16'd1,     1'b0};
      vecs[5] = '{8'd255, 8'd255, 3'd6, 16'd255,   1'b1};
      vecs[6] = '{8'd0,   8'd128, 3'd7, 16'd16512, 1'b0};
      vecs[7] = '{8'd129, 8'd0,   3'd0, 16'd0,     1'b1};
      vecs[8] = '{8'd64,  8'd0,   3'd2, 16'd24832, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      r129 = '0; r256 = '0; tag_in = '0;
      hold_v = 1'b0; hold_dout = '0; acc = 1'b0;
      cur_e = '{16'd0, 3'd0, 1'b0};
      #22;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_tag", int'(tag_out), 0);
      chk("rst_err", int'(range_err), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", int'(in_ready), 1);

      // Single items with exact latency and known results.
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         set_item(int'(vecs[i].r129), int'(vecs[i].r256), int'(vecs[i].tag));
         cur_e = '{vecs[i].dout, vecs[i].tag, vecs[i].err};
         cyc();
         chk("vec_accept", int'(acc), 1);
         in_valid = 1'b0;
         cyc();
         chk("vec_lat_early", int'(out_valid), 0);
         cyc();
         chk("vec_lat_valid", int'(out_valid), 1);
         chk("vec_dout", int'(dout), int'(vecs[i].dout));
         chk("vec_tag", int'(tag_out), int'(vecs[i].tag));
         chk("vec_err", int'(range_err), int'(vecs[i].err));
         cyc();
      end

      // Backpressure: four offered, three fit, then drain with push-while-pop.
      bp_a = '{10, 200, 128, 55};
      bp_b = '{20, 7, 255, 99};
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         if (idx < 4) set_item(bp_a[idx], bp_b[idx], idx + 4);
         cyc();
         if (acc) idx++;
      end
      chk("bp_accepted", idx, 3);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_head", int'(dout), int'(model(bp_a[0], bp_b[0], 4).dout));
      out_ready = 1'b1;
      for (int c = 0; c < 12 && !(idx == 4 && sb.size() == 0); c++) begin
         if (idx < 4) set_item(bp_a[idx], bp_b[idx], idx + 4);
         else in_valid = 1'b0;
         cyc();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("bp_all_in", idx, 4);
      chk("bp_drained", sb.size(), 0);

      // Reset with items in flight.
      out_ready = 1'b0;
      set_item(3, 4, 1); cyc();
      set_item(5, 6, 2); cyc();
      in_valid = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_dout", int'(dout), 0);
      sb.delete();
      hold_v = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cyc();
         chk("postrst_idle", int'(out_valid), 0);
      end

      // Random residues (including out-of-range r129) with random stalls.
      idx = 0;
      budget = 0;
      set_item(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
      while (idx < 400 && budget < 4000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         cyc();
         budget++;
         if (acc) begin
            idx++;
            set_item(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
         end
      end
      chk("rand_budget", idx, 400);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && sb.size() != 0; c++) cyc();
      chk("rand_drained", sb.size(), 0);

      // Every representable X, back-to-back, with random output stalls.
      idx = 0;
      budget = 0;
      while (idx < 33024 && budget < 70000) begin
         in_valid  = 1'b1;
         r129      = 8'(idx % 129);
         r256      = 8'(idx % 256);
         tag_in    = 3'(idx);
         cur_e     = '{16'(idx), 3'(idx), 1'b0};
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
         budget++;
         if (acc) idx++;
      end
      chk("sweep_budget", idx, 33024);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && sb.size() != 0; c++) cyc();
      chk("sweep_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
